// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch, load and committed-store requests onto one memory controller
// priority store > load > fetch, with fetch forced after STARVE_LIMIT consecutive losses
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int ID_W         = 4,
    parameter int OP_W         = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            stall,
    input  logic            f_req,
    input  logic [XLEN-1:0] f_addr,
    output logic            f_ack,
    input  logic            l_req,
    input  logic [OP_W-1:0] l_op,
    input  logic [XLEN-1:0] l_addr,
    input  logic [ID_W-1:0] l_id,
    output logic            l_ack,
    input  logic            s_req,
    input  logic [OP_W-1:0] s_op,
    input  logic [XLEN-1:0] s_addr,
    input  logic [XLEN-1:0] s_val,
    output logic            s_ack,
    output logic            s_done,
    input  logic            mc_busy,
    input  logic            mc_inst_ready,
    input  logic            mc_data_ready,
    output logic            mc_i_en,
    output logic [XLEN-1:0] mc_i_addr,
    output logic            mc_l_en,
    output logic [OP_W-1:0] mc_l_op,
    output logic [XLEN-1:0] mc_l_addr,
    output logic [ID_W-1:0] mc_l_id,
    output logic            mc_s_en,
    output logic [OP_W-1:0] mc_s_op,
    output logic [XLEN-1:0] mc_s_addr,
    output logic [XLEN-1:0] mc_s_val,
    output logic            arb_busy
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, B_INST, B_LOAD, B_STORE} state_t;

    state_t        state, nxt;
    logic [SW-1:0] starve_cnt;
    logic [1:0]    st_cnt;
    logic          cool, can_grant, starved, g_f, g_l, g_s, st_done;

    // cool marks the mandatory idle cycle after a transaction ends
    always_comb begin
        can_grant = state == IDLE && !cool && !stall && !flush;
        starved   = starve_cnt == SW'(STARVE_LIMIT);
        g_s       = can_grant && s_req;
        g_f       = can_grant && !s_req && f_req && (starved || !l_req);
        g_l       = can_grant && !s_req && l_req && !g_f;
        st_done   = state == B_STORE && st_cnt == 2'd2 && !mc_busy;
        nxt = g_s ? B_STORE : g_l ? B_LOAD : g_f ? B_INST :
              (state == B_INST && (flush || mc_inst_ready)) ? IDLE :
              (state == B_LOAD && (flush || mc_data_ready)) ? IDLE :
              st_done ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            st_cnt     <= '0;
            cool       <= 1'b0;
            f_ack      <= 1'b0;
            l_ack      <= 1'b0;
            s_ack      <= 1'b0;
            s_done     <= 1'b0;
            mc_i_en    <= 1'b0;
            mc_l_en    <= 1'b0;
            mc_s_en    <= 1'b0;
            arb_busy   <= 1'b0;
            mc_i_addr  <= '0;
            mc_l_op    <= '0;
            mc_l_addr  <= '0;
            mc_l_id    <= '0;
            mc_s_op    <= '0;
            mc_s_addr  <= '0;
            mc_s_val   <= '0;
        end else if (rdy) begin
            state    <= nxt;
            arb_busy <= nxt != IDLE;
            cool     <= state != IDLE && nxt == IDLE;
            s_done   <= st_done;
            f_ack    <= g_f;
            l_ack    <= g_l;
            s_ack    <= g_s;
            mc_i_en  <= g_f;
            mc_l_en  <= g_l;
            mc_s_en  <= g_s;
            st_cnt   <= state == B_STORE ? (st_cnt == 2'd2 ? st_cnt : st_cnt + 2'd1) : 2'd0;
            if (g_f)
                starve_cnt <= '0;
            else if ((g_l || g_s) && f_req && !starved)
                starve_cnt <= starve_cnt + 1'b1;
            if (g_f)
                mc_i_addr <= f_addr;
            if (g_l) begin
                mc_l_op   <= l_op;
                mc_l_addr <= l_addr;
                mc_l_id   <= l_id;
            end
            if (g_s) begin
                mc_s_op   <= s_op;
                mc_s_addr <= s_addr;
                mc_s_val  <= s_val;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_arbiter;
    localparam int STARVE = 4;
    localparam logic [5:0] OP_SW = 6'd13;

    logic clk = 0, rst, rdy, flush, stall;
    logic f_req, l_req, s_req, mc_busy, mc_inst_ready, mc_data_ready;
    logic [31:0] f_addr, l_addr, s_addr, s_val;
    logic [5:0] l_op, s_op;
    logic [3:0] l_id;
    logic f_ack, l_ack, s_ack, s_done, mc_i_en, mc_l_en, mc_s_en, arb_busy;
    logic [31:0] mc_i_addr, mc_l_addr, mc_s_addr, mc_s_val;
    logic [5:0] mc_l_op, mc_s_op;
    logic [3:0] mc_l_id;

    int n_cmp = 0, n_err = 0;

    // model: busy kind 0 none / 1 fetch / 2 load / 3 store
    int m_kind, m_age, m_starve;
    bit m_gap;
    logic [7:0] e_flags;
    logic [31:0] e_i_addr, e_l_addr, e_s_addr, e_s_val;
    logic [5:0] e_l_op, e_s_op;
    logic [3:0] e_l_id;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .l_req(l_req), .l_op(l_op), .l_addr(l_addr), .l_id(l_id), .l_ack(l_ack),
        .s_req(s_req), .s_op(s_op), .s_addr(s_addr), .s_val(s_val), .s_ack(s_ack), .s_done(s_done),
        .mc_busy(mc_busy), .mc_inst_ready(mc_inst_ready), .mc_data_ready(mc_data_ready),
        .mc_i_en(mc_i_en), .mc_i_addr(mc_i_addr),
        .mc_l_en(mc_l_en), .mc_l_op(mc_l_op), .mc_l_addr(mc_l_addr), .mc_l_id(mc_l_id),
        .mc_s_en(mc_s_en), .mc_s_op(mc_s_op), .mc_s_addr(mc_s_addr), .mc_s_val(mc_s_val),
        .arb_busy(arb_busy)
    );

    task automatic model_update();
        int win;
        bit fin;
        if (!rst) begin
            m_kind = 0; m_age = 0; m_gap = 0; m_starve = 0; e_flags = 0;
            e_i_addr = 0; e_l_addr = 0; e_s_addr = 0; e_s_val = 0;
            e_l_op = 0; e_s_op = 0; e_l_id = 0;
        end else if (rdy) begin
            win = 0;
            if (m_kind == 0 && !m_gap && !stall && !flush) begin
                if (s_req) win = 3;
                else if (f_req && (m_starve == STARVE || !l_req)) win = 1;
                else if (l_req) win = 2;
            end
            fin = (m_kind == 1 && (flush || mc_inst_ready)) ||
                  (m_kind == 2 && (flush || mc_data_ready)) ||
                  (m_kind == 3 && m_age >= 2 && !mc_busy);
            e_flags = {win == 1, win == 2, win == 3, m_kind == 3 && fin,
                       win == 1, win == 2, win == 3, win != 0 || (m_kind != 0 && !fin)};
            if (win == 1) begin
                e_i_addr = f_addr;
                m_starve = 0;
            end else if (win != 0 && f_req && m_starve < STARVE) m_starve++;
            if (win == 2) begin e_l_op = l_op; e_l_addr = l_addr; e_l_id = l_id; end
            if (win == 3) begin e_s_op = s_op; e_s_addr = s_addr; e_s_val = s_val; end
            m_gap = fin;
            m_age = win != 0 ? 0 : m_age + 1;
            m_kind = win != 0 ? win : fin ? 0 : m_kind;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 1; rdy = 1; flush = 0; stall = 0;
        f_req = 0; l_req = 0; s_req = 0;
        mc_busy = 0; mc_inst_ready = 0; mc_data_ready = 0;
    endtask

    task automatic settle();
        quiet();
        mc_inst_ready = 1; mc_data_ready = 1;
        repeat (6) step();
        mc_inst_ready = 0; mc_data_ready = 0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 0; f_req = 1; l_req = 1; s_req = 1;
        f_addr = $urandom; l_addr = $urandom; s_addr = $urandom; s_val = $urandom;
        l_op = 6'($urandom); s_op = 6'($urandom); l_id = 4'($urandom);
        step(); step();
        n_cmp++;
        if ({f_ack, l_ack, s_ack, s_done, mc_i_en, mc_l_en, mc_s_en, arb_busy} !== 8'h0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {f_ack, l_ack, s_ack, s_done, mc_i_en, mc_l_en, mc_s_en, arb_busy});
        end
        n_cmp++;
        if ({mc_i_addr, mc_l_addr, mc_s_addr, mc_s_val, mc_l_op, mc_s_op, mc_l_id} !== '0) begin
            n_err++;
            $display("FAIL reset_buses: got nonzero, expected all zero");
        end
        quiet();
        step();
        n_cmp++;
        if (arb_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: arb_busy got %b expected 0", arb_busy); end
    endtask

    task automatic test_single_fetch();
        settle();
        f_req = 1; f_addr = 32'h1000;
        step();
        f_req = 0;
        n_cmp++;
        if ({f_ack, mc_i_en} !== 2'b11) begin n_err++; $display("FAIL fetch_ack: got %b expected 11", {f_ack, mc_i_en}); end
        n_cmp++;
        if (mc_i_addr !== 32'h1000) begin n_err++; $display("FAIL fetch_addr: got %h expected 00001000", mc_i_addr); end
        repeat (4) step();
        n_cmp++;
        if ({mc_i_en, arb_busy, mc_i_addr} !== {2'b01, 32'h1000}) begin
            n_err++; $display("FAIL fetch_wait: en/busy got %b%b expected 01", mc_i_en, arb_busy);
        end
        mc_inst_ready = 1;
        step();
        mc_inst_ready = 0;
        n_cmp++;
        if (arb_busy !== 1'b0) begin n_err++; $display("FAIL fetch_done: arb_busy got %b expected 0", arb_busy); end
    endtask

    task automatic test_simultaneous();
        int order[$];
        int dones = 0;
        settle();
        s_req = 1; l_req = 1; f_req = 1;
        s_addr = $urandom; s_val = $urandom; l_addr = $urandom; f_addr = $urandom;
        mc_inst_ready = 1; mc_data_ready = 1;
        for (int i = 0; i < 60 && order.size() < 3; i++) begin
            step();
            if (s_ack) begin order.push_back(3); s_req = 0; end
            if (l_ack) begin order.push_back(2); l_req = 0; end
            if (f_ack) begin order.push_back(1); f_req = 0; end
            if (s_done) dones++;
        end
        repeat (6) begin step(); if (s_done) dones++; end
        n_cmp++;
        if (order.size() != 3 || order[0] != 3 || order[1] != 2 || order[2] != 1) begin
            n_err++; $display("FAIL sim_order: got %p expected '{3,2,1}", order);
        end
        n_cmp++;
        if (dones != 1) begin n_err++; $display("FAIL sim_done: s_done pulses got %0d expected 1", dones); end
    endtask

    task automatic test_starve();
        int loads = 0, first = -1, second = -1;
        quiet(); rst = 0; step(); rst = 1;
        l_req = 1; f_req = 1; mc_data_ready = 1; mc_inst_ready = 1;
        l_addr = $urandom; f_addr = $urandom;
        for (int i = 0; i < 200 && second < 0; i++) begin
            step();
            if (l_ack) begin loads++; l_addr = $urandom; l_id = 4'($urandom); end
            if (f_ack) begin
                if (first < 0) first = loads; else second = loads - first;
            end
        end
        n_cmp++;
        if (first != STARVE) begin n_err++; $display("FAIL starve_first: loads before fetch got %0d expected %0d", first, STARVE); end
        n_cmp++;
        if (second != STARVE) begin n_err++; $display("FAIL starve_clear: loads between fetches got %0d expected %0d", second, STARVE); end
    endtask

    task automatic test_flush_load();
        int regrants = 0;
        settle();
        l_req = 1; l_addr = 32'h2000; l_id = 4'd3; l_op = 6'd3;
        step();
        l_req = 0;
        n_cmp++;
        if ({l_ack, mc_l_en, mc_l_addr, mc_l_id} !== {2'b11, 32'h2000, 4'd3}) begin
            n_err++; $display("FAIL fl_grant: got ack=%b addr=%h id=%0d expected 1/00002000/3", l_ack, mc_l_addr, mc_l_id);
        end
        flush = 1;
        step();
        flush = 0;
        n_cmp++;
        if (arb_busy !== 1'b0) begin n_err++; $display("FAIL fl_idle: arb_busy got %b expected 0", arb_busy); end
        mc_data_ready = 1;
        repeat (4) begin step(); if (l_ack || mc_l_en || arb_busy) regrants++; end
        mc_data_ready = 0;
        n_cmp++;
        if (regrants != 0) begin n_err++; $display("FAIL fl_regrant: active cycles got %0d expected 0", regrants); end
    endtask

    task automatic test_flush_store();
        int dones = 0, early = 0;
        bit seen = 0;
        settle();
        s_req = 1; s_addr = 32'h30000; s_op = OP_SW; s_val = $urandom; mc_busy = 1;
        step();
        s_req = 0;
        n_cmp++;
        if ({s_ack, mc_s_en, mc_s_addr, mc_s_op} !== {2'b11, 32'h30000, OP_SW}) begin
            n_err++; $display("FAIL fs_grant: got ack=%b addr=%h expected 1/00030000", s_ack, mc_s_addr);
        end
        flush = 1;
        repeat (3) begin step(); if (!arb_busy || s_done) early++; end
        flush = 0;
        n_cmp++;
        if (early != 0) begin n_err++; $display("FAIL fs_hold: left B_STORE early in %0d cycles expected 0", early); end
        mc_busy = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_done) begin dones++; seen = 1; end
        end
        n_cmp++;
        if (!seen || dones != 1) begin n_err++; $display("FAIL fs_done: s_done pulses got %0d expected 1", dones); end
    endtask

    task automatic test_rst_mid();
        settle();
        f_req = 1; f_addr = $urandom;
        step();
        f_req = 0;
        step(); step();
        rst = 0;
        step();
        rst = 1;
        n_cmp++;
        if ({f_ack, l_ack, s_ack, s_done, mc_i_en, mc_l_en, mc_s_en, arb_busy, mc_i_addr} !== '0) begin
            n_err++; $display("FAIL rst_mid: busy=%b i_addr=%h expected all zero", arb_busy, mc_i_addr);
        end
    endtask

    task automatic test_rdy_hold();
        int held = 0, dup = 0;
        settle();
        l_req = 1; l_addr = $urandom;
        step();
        rdy = 0; l_req = 0;
        repeat (3) begin step(); if (mc_l_en && l_ack) held++; end
        rdy = 1;
        repeat (3) begin step(); if (mc_l_en || l_ack) dup++; end
        n_cmp++;
        if (held != 3) begin n_err++; $display("FAIL rdy_hold: held cycles got %0d expected 3", held); end
        n_cmp++;
        if (dup != 0) begin n_err++; $display("FAIL rdy_dup: repeated pulses got %0d expected 0", dup); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 99) != 0;
            rdy = $urandom_range(0, 9) != 0;
            flush = $urandom_range(0, 14) == 0;
            stall = $urandom_range(0, 7) == 0;
            f_req = $urandom_range(0, 2) == 0;
            l_req = $urandom_range(0, 2) == 0;
            s_req = $urandom_range(0, 3) == 0;
            f_addr = $urandom; l_addr = $urandom; s_addr = $urandom; s_val = $urandom;
            l_op = 6'($urandom); s_op = 6'($urandom); l_id = 4'($urandom);
            mc_busy = $urandom_range(0, 1);
            mc_inst_ready = $urandom_range(0, 3) == 0;
            mc_data_ready = $urandom_range(0, 3) == 0;
            step();
            n_cmp++;
            if ({f_ack, l_ack, s_ack, s_done, mc_i_en, mc_l_en, mc_s_en, arb_busy} !== e_flags) begin
                n_err++;
                $display("FAIL rnd_flags @%0d: got %b expected %b", i,
                         {f_ack, l_ack, s_ack, s_done, mc_i_en, mc_l_en, mc_s_en, arb_busy}, e_flags);
            end
            n_cmp++;
            if ({mc_i_addr, mc_l_op, mc_l_addr, mc_l_id, mc_s_op, mc_s_addr, mc_s_val} !==
                {e_i_addr, e_l_op, e_l_addr, e_l_id, e_s_op, e_s_addr, e_s_val}) begin
                n_err++;
                $display("FAIL rnd_buses @%0d: got %h/%h/%h expected %h/%h/%h", i,
                         mc_i_addr, mc_l_addr, mc_s_addr, e_i_addr, e_l_addr, e_s_addr);
            end
        end
    endtask

    initial begin
        quiet();
        f_addr = 0; l_addr = 0; s_addr = 0; s_val = 0; l_op = 0; s_op = 0; l_id = 0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starve();
        test_flush_load();
        test_flush_store();
        test_rst_mid();
        test_rdy_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: XLEN, 32, data/address width; ID_W, 4, ROB id width (`ROB_SIZE_WIDTH); OP_W, 6, op width (`INST_OP_WIDTH); STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced.
REQ-002 SHALL have ports: clk in 1, sole clock; rst in 1, synchronous active-low reset; rdy in 1, global enable (no state change when 0).
REQ-003 SHALL have ports: flush in 1, pipeline flush; stall in 1, blocks new grants.
REQ-004 SHALL have ports: f_req in 1, f_addr in XLEN: fetch request; f_ack out 1, fetch granted.
REQ-005 SHALL have ports: l_req in 1, l_op in OP_W, l_addr in XLEN, l_id in ID_W: load request; l_ack out 1, load granted.
REQ-006 SHALL have ports: s_req in 1, s_op in OP_W, s_addr in XLEN, s_val in XLEN: committed store request; s_ack out 1, store granted; s_done out 1, store finished.
REQ-007 SHALL have ports: mc_busy in 1, mc_inst_ready in 1, mc_data_ready in 1: memory-controller status.
REQ-008 SHALL have ports: mc_i_en out 1, mc_i_addr out XLEN; mc_l_en out 1, mc_l_op out OP_W, mc_l_addr out XLEN, mc_l_id out ID_W; mc_s_en out 1, mc_s_op out OP_W, mc_s_addr out XLEN, mc_s_val out XLEN; arb_busy out 1.

Function
REQ-009 SHALL be a state machine: IDLE, B_INST, B_LOAD, B_STORE; all outputs registered.
REQ-010 SHALL, in IDLE with rdy=1, stall=0, flush=0 and any req high, grant one requester at the clock edge.
REQ-011 SHALL use priority store > load > fetch, except fetch wins over load when starve_cnt == STARVE_LIMIT; store always wins.
REQ-012 SHALL increment starve_cnt (saturating at STARVE_LIMIT) when f_req=1 and another requester is granted; clear it on fetch grant.
REQ-013 SHALL, on grant, drive the matching ack and mc_*_en high for exactly one cycle, with the captured address/op/id/val on the mc_* buses; ack and en SHALL be in the same cycle.
REQ-014 SHALL hold mc_* address/op/id/val buses stable until the transaction ends; an en pulse occurs only on grant.
REQ-015 SHALL rely on requesters dropping req the cycle after ack; a req still high in that cycle SHALL NOT be granted again.
REQ-016 SHALL move IDLE->B_INST/B_LOAD/B_STORE on grant; B_INST->IDLE on mc_inst_ready=1; B_LOAD->IDLE on mc_data_ready=1.
REQ-017 SHALL leave B_STORE->IDLE when mc_busy=0, sampled no earlier than the second cycle after the mc_s_en pulse, and pulse s_done for one cycle on that exit.
REQ-018 SHALL give a minimum of one IDLE cycle between the end of a transaction and the next grant (grant-to-grant minimum 3 cycles).
REQ-019 SHALL drive arb_busy=1 whenever state != IDLE or a grant is being issued.
REQ-020 SHALL, on flush=1 in IDLE/B_INST/B_LOAD, return to IDLE next cycle, drop the transaction, suppress acks and enables that cycle, and leave starve_cnt unchanged.
REQ-021 SHALL, on flush=1 in B_STORE, stay in B_STORE and complete the store per REQ-017 (committed stores are not cancelled).
REQ-022 SHALL, when stall=1, issue no grant and freeze starve_cnt; in-flight completion SHALL still be observed.
REQ-023 SHALL, when rdy=0, hold all state and outputs; en/ack/s_done pulses SHALL NOT be repeated once rdy returns.
REQ-024 SHALL ignore mc_inst_ready/mc_data_ready in states where they are not expected.

Reset
REQ-025 SHALL, when rst=0 at a clock edge (any state, including mid-transaction), enter IDLE, clear starve_cnt, and drive every output to 0.
REQ-026 SHALL make its first grant no earlier than the first edge after rst returns to 1.

Verification
REQ-027 Single fetch: f_req=1, f_addr=0x1000 -> next cycle f_ack=1, mc_i_en=1, mc_i_addr=0x1000; mc_inst_ready 5 cycles later -> IDLE, arb_busy=0.
REQ-028 Simultaneous: s_req, l_req, f_req all 1 -> store granted first, then load, then fetch; s_done pulses once per store.
REQ-029 Starvation: l_req held with back-to-back new loads, f_req held -> fetch granted after exactly 4 load grants, starve_cnt back to 0.
REQ-030 Flush in B_LOAD (l_addr=0x2000, l_id=3) -> IDLE next cycle, later mc_data_ready ignored, no re-grant without new l_req.
REQ-031 Flush in B_STORE (s_addr=0x30000, SW) -> stays in B_STORE, s_done pulses when mc_busy falls.
REQ-032 rst=0 mid-B_INST -> all outputs 0 next cycle; rdy=0 during grant -> en pulse held, not duplicated.
